// File: rtl/display_pkg.sv
// Shared types and constants for the display arbiter and its BCD converter.
package display_pkg;

   typedef enum logic [1:0] {IDLE, CONVERT, HOLD} state_t;

   localparam int DIGITS      = 4;
   localparam int BIN_W       = 14;
   localparam int BCD_MAX     = 9999;
   localparam int CONV_CYCLES = 14;
   localparam logic [3:0] ERR_DIGIT = 4'hE;

   function automatic logic is_over(input logic [BIN_W-1:0] v);
      return v > BIN_W'(BCD_MAX);
   endfunction

endpackage

// File: rtl/display_arb_ctrl_if.sv
// Requester handshakes and display-mux outputs of the display arbiter.
interface display_arb_ctrl_if;
   import display_pkg::*;

   logic [BIN_W-1:0] req0_data;
   logic             req0_valid;
   logic             req0_ready;
   logic [BIN_W-1:0] req1_data;
   logic             req1_valid;
   logic             req1_ready;
   logic [3:0]       bcd0;
   logic [3:0]       bcd1;
   logic [3:0]       bcd2;
   logic [3:0]       bcd3;
   logic             owner;
   logic             busy;

   modport master (
      output req0_data, req0_valid, req1_data, req1_valid,
      input  req0_ready, req1_ready, bcd0, bcd1, bcd2, bcd3, owner, busy
   );

   modport slave (
      input  req0_data, req0_valid, req1_data, req1_valid,
      output req0_ready, req1_ready, bcd0, bcd1, bcd2, bcd3, owner, busy
   );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift iteration per cycle after start.
// done and bcd are combinational during the final iteration cycle.
module bin2bcd_seq
   import display_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  done,
   output logic [DIGITS*4-1:0]   bcd
);

   localparam int SR_W  = DIGITS*4 + BIN_W;
   localparam int CNT_W = $clog2(CONV_CYCLES + 1);

   logic [SR_W-1:0]  sr_reg;
   logic [SR_W-1:0]  sr_adj;
   logic [SR_W-1:0]  sr_step;
   logic [CNT_W-1:0] cnt_reg;

   assign sr_adj[BIN_W-1:0] = sr_reg[BIN_W-1:0];

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_adj
         assign sr_adj[BIN_W+4*gi +: 4] = (sr_reg[BIN_W+4*gi +: 4] >= 4'd5) ?
                                          sr_reg[BIN_W+4*gi +: 4] + 4'd3 :
                                          sr_reg[BIN_W+4*gi +: 4];
      end
   endgenerate

   assign sr_step = sr_adj << 1;

   always_ff @(posedge clk) begin
      if (rst) begin
         sr_reg  <= '0;
         cnt_reg <= '0;
      end else if (start) begin
         sr_reg  <= {{(DIGITS*4){1'b0}}, bin};
         cnt_reg <= CNT_W'(CONV_CYCLES);
      end else if (cnt_reg != '0) begin
         sr_reg  <= sr_step;
         cnt_reg <= cnt_reg - 1'b1;
      end
   end

   // The last iteration's result is handed out directly so the caller can
   // register it on the same edge that finishes the conversion.
   assign done = (cnt_reg == CNT_W'(1));
   assign bcd  = sr_step[SR_W-1 -: DIGITS*4];

endmodule

// File: rtl/display_arb_ctrl.sv
// Round-robin sharing of the 4-digit display between two requesters.
// Optional DISPLAY_OVF_ERR_EN shows EEEE for values above 9999 instead of saturating.
module display_arb_ctrl
   import display_pkg::*;
#(
   parameter int HOLD_CYCLES = 50_000_000,
   parameter int HOLD_W      = 26
)(
   input logic               clk,
   input logic               rst,
   display_arb_ctrl_if.slave bus
);

   state_t                state_reg, state_next;
   logic                  last_grant_reg;
   logic                  pend_owner_reg;
   logic                  owner_reg;
   logic [DIGITS*4-1:0]   disp_reg;
   logic [HOLD_W-1:0]     hold_cnt_reg;
   logic                  choice;
   logic                  transfer;
   logic [BIN_W-1:0]      chosen_data;
   logic [BIN_W-1:0]      conv_bin;
   logic                  conv_done;
   logic [DIGITS*4-1:0]   conv_bcd;
   logic [DIGITS*4-1:0]   conv_result;

   // Tie goes to whoever did not win last time.
   always_comb begin
      choice = 1'b0;
      if (bus.req0_valid && bus.req1_valid) choice = !last_grant_reg;
      else if (bus.req1_valid)              choice = 1'b1;
   end

   assign transfer       = (state_reg == IDLE) && !rst && (bus.req0_valid || bus.req1_valid);
   assign bus.req0_ready = transfer && !choice;
   assign bus.req1_ready = transfer && choice;
   assign chosen_data    = choice ? bus.req1_data : bus.req0_data;

`ifdef DISPLAY_OVF_ERR_EN
   logic ovf_reg;

   assign conv_bin    = is_over(chosen_data) ? '0 : chosen_data;
   assign conv_result = ovf_reg ? {DIGITS{ERR_DIGIT}} : conv_bcd;

   always_ff @(posedge clk) begin
      if (rst)           ovf_reg <= 1'b0;
      else if (transfer) ovf_reg <= is_over(chosen_data);
   end
`else
   assign conv_bin    = is_over(chosen_data) ? BIN_W'(BCD_MAX) : chosen_data;
   assign conv_result = conv_bcd;
`endif

   bin2bcd_seq u_bin2bcd (
      .clk   (clk),
      .rst   (rst),
      .start (transfer),
      .bin   (conv_bin),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (transfer)  state_next = CONVERT;
         CONVERT: if (conv_done) state_next = HOLD;
         HOLD:    if (hold_cnt_reg == HOLD_W'(HOLD_CYCLES - 1)) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_reg <= 1'b1;
         pend_owner_reg <= 1'b0;
         owner_reg      <= 1'b0;
         disp_reg       <= '0;
         hold_cnt_reg   <= '0;
      end else begin
         if (transfer) begin
            last_grant_reg <= choice;
            pend_owner_reg <= choice;
         end
         // Digits and owner change together, only once the conversion is whole.
         if (state_reg == CONVERT && conv_done) begin
            disp_reg     <= conv_result;
            owner_reg    <= pend_owner_reg;
            hold_cnt_reg <= '0;
         end else if (state_reg == HOLD) begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
         end
      end
   end

   assign bus.bcd0  = disp_reg[3:0];
   assign bus.bcd1  = disp_reg[7:4];
   assign bus.bcd2  = disp_reg[11:8];
   assign bus.bcd3  = disp_reg[15:12];
   assign bus.owner = owner_reg;
   assign bus.busy  = (state_reg != IDLE);

endmodule
